// File: rtl/serial_to_parallel_stream.sv
// Lane-by-lane stream assembler: packs lane_width-bit beats into width-bit words with
// run-time lane order and early flush on in_last. Define SERIAL_TO_PARALLEL_PARITY_EN to add out_parity.
module serial_to_parallel_stream #(
    parameter int width      = 8,
    parameter int lane_width = 1,
    localparam int beats     = width / lane_width,
    localparam int cnt_w     = $clog2(beats + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  msb_first,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [lane_width-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [width-1:0]      out_data,
    output logic [cnt_w-1:0]      out_count,
    output logic                  out_last
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    localparam logic [cnt_w-1:0] last_k = cnt_w'(beats - 1);

    logic [cnt_w-1:0] k, k_next, lane_idx;
    logic [width-1:0] acc, acc_next, merged;
    logic             order, order_next, order_eff;
    logic             beat, complete;
    logic             out_valid_next, out_last_next;
    logic [width-1:0] out_data_next;
    logic [cnt_w-1:0] out_count_next;

    // The holding register may reload on the same edge the consumer takes the old word.
    assign in_ready  = !out_valid || out_ready;
    assign beat      = in_valid && in_ready;
    assign complete  = beat && ((k == last_k) || in_last);
    assign order_eff = (k == '0) ? msb_first : order;
    assign lane_idx  = order_eff ? (last_k - k) : k;

    always_comb begin
        merged = acc;
        for (int i = 0; i < beats; i++) begin
            if (lane_idx == cnt_w'(i)) begin
                merged[i*lane_width +: lane_width] = in_data;
            end
        end
    end

    always_comb begin
        k_next         = k;
        acc_next       = acc;
        order_next     = order;
        out_valid_next = out_valid;
        out_data_next  = out_data;
        out_count_next = out_count;
        out_last_next  = out_last;
        if (out_valid && out_ready) begin
            out_valid_next = 1'b0;
        end
        if (beat) begin
            order_next = order_eff;
            if (complete) begin
                out_valid_next = 1'b1;
                out_data_next  = merged;
                out_count_next = k + cnt_w'(1);
                out_last_next  = in_last;
                acc_next       = '0;
                k_next         = '0;
            end else begin
                acc_next = merged;
                k_next   = k + cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            acc       <= '0;
            order     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
        end else begin
            k         <= k_next;
            acc       <= acc_next;
            order     <= order_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
            out_count <= out_count_next;
            out_last  <= out_last_next;
        end
    end

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    // Parity travels with the word so it stays coherent under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (complete) begin
            out_parity <= ^merged;
        end
    end
`endif

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
// Self-checking bench for serial_to_parallel_stream: directed steps plus randomized traffic
// compared against a queue-based word model; covers lane_width 1 and 2 instances.
module tb_serial_to_parallel_stream;

    localparam int W     = 8;
    localparam int LW    = 1;
    localparam int BEATS = W / LW;
    localparam int CW    = $clog2(BEATS + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          msb_first = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [LW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_last;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;

    logic       b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b0;
    logic [1:0] b_in_data = '0;
    logic       b_in_ready, b_out_valid, b_out_last;
    logic [7:0] b_out_data;
    logic [2:0] b_out_count;

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    logic out_parity, b_out_parity;
`endif

    serial_to_parallel_stream #(.width(W), .lane_width(LW)) dut (
        .clk(clk), .rst_n(rst_n), .msb_first(msb_first),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_last(out_last)
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    serial_to_parallel_stream #(.width(8), .lane_width(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .msb_first(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_count(b_out_count), .out_last(b_out_last)
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        , .out_parity(b_out_parity)
`endif
    );

    typedef struct {
        logic [W-1:0] data;
        int           count;
        logic         last;
    } word_t;

    int    tests = 0;
    int    fails = 0;
    word_t exp_q[$];
    int    beat_q[$];
    logic  mdl_ord = 1'b0;
    logic  mdl_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: gather beats, then place beat j into lane j or beats-1-j.
    task automatic model_beat(input logic [LW-1:0] d, input logic l, input logic m);
        word_t w;
        int    lane;
        if (beat_q.size() == 0) mdl_ord = m;
        beat_q.push_back(int'(d));
        if (beat_q.size() == BEATS || l) begin
            w.data = '0;
            for (int j = 0; j < beat_q.size(); j++) begin
                lane = mdl_ord ? (BEATS - 1 - j) : j;
                w.data = w.data | (W'(beat_q[j]) << (lane * LW));
            end
            w.count = beat_q.size();
            w.last  = l;
            exp_q.push_back(w);
            beat_q.delete();
            mdl_valid = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [LW-1:0] d, input logic l,
                                 input logic m, input logic ordy, output logic accepted);
        logic exp_rdy;
        in_valid = v; in_data = d; in_last = l; msb_first = m; out_ready = ordy;
        #1;
        exp_rdy = !mdl_valid || ordy;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(mdl_valid));
        if (mdl_valid && exp_q.size() > 0) begin
            check("out_data", 32'(out_data), 32'(exp_q[0].data));
            check("out_count", 32'(out_count), 32'(exp_q[0].count));
            check("out_last", 32'(out_last), 32'(exp_q[0].last));
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
            check("out_parity", 32'(out_parity), 32'(^exp_q[0].data));
`endif
        end
        if (mdl_valid && ordy) begin
            void'(exp_q.pop_front());
            mdl_valid = 1'b0;
        end
        accepted = v && exp_rdy;
        if (accepted) model_beat(d, l, m);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sendBits(input logic [7:0] vec, input int n, input logic last_at_end,
                            input logic m, input int toggle_after);
        logic acc, mm, ll;
        int   tries;
        for (int j = 0; j < n; j++) begin
            mm = (toggle_after > 0 && j >= toggle_after) ? !m : m;
            ll = last_at_end && (j == n - 1);
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 20) begin
                applyStimulus(1'b1, LW'(vec[j]), ll, mm, 1'b1, acc);
                tries++;
            end
            check("beat_accept", 32'(acc), 32'd1);
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic checkOutput(input logic [7:0] d, input int c, input logic l);
        check("word_valid", 32'(out_valid), 32'd1);
        check("word_data", 32'(out_data), 32'(d));
        check("word_count", 32'(out_count), 32'(c));
        check("word_last", 32'(out_last), 32'(l));
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        check("word_parity", 32'(out_parity), 32'(^d));
`endif
    endtask

    task automatic doReset();
        in_valid = 1'b0; in_last = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        check("rst_parity", 32'(out_parity), 32'd0);
`endif
        exp_q.delete(); beat_q.delete(); mdl_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic acc;
        int   tries;
        repeat (2) @(negedge clk);
        check("reset_hold_valid", 32'(out_valid), 32'd0);
        check("reset_hold_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-bit lanes on the second instance.
        for (int j = 0; j < 4; j++) begin
            b_in_valid = 1'b1;
            b_in_data  = 2'((8'h39 >> (2 * j)) & 8'h3);
            #1;
            check("b_in_ready", 32'(b_in_ready), 32'd1);
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        check("b_valid", 32'(b_out_valid), 32'd1);
        check("b_data", 32'(b_out_data), 32'h39);
        check("b_count", 32'(b_out_count), 32'd4);
        check("b_last", 32'(b_out_last), 32'd0);
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        check("b_parity", 32'(b_out_parity), 32'd0);
`endif

        // Bits 1,0,1,1,0,0,1,0 as vector bits 0..7.
        sendBits(8'h4D, 8, 1'b0, 1'b0, 0);
        checkOutput(8'h4D, 8, 1'b0);
        sendBits(8'h4D, 8, 1'b0, 1'b1, 3);
        checkOutput(8'hB2, 8, 1'b0);
        sendBits(8'h03, 3, 1'b1, 1'b0, 0);
        checkOutput(8'h03, 3, 1'b1);
        sendBits(8'h03, 3, 1'b1, 1'b1, 0);
        checkOutput(8'hC0, 3, 1'b1);
        sendBits(8'h4D, 8, 1'b0, 1'b0, 0);
        checkOutput(8'h4D, 8, 1'b0);
        sendBits(8'hFF, 8, 1'b1, 1'b0, 0);
        checkOutput(8'hFF, 8, 1'b1);

        // Backpressure with a word held, then resume.
        sendBits(8'hA5, 8, 1'b0, 1'b0, 0);
        checkOutput(8'hA5, 8, 1'b0);
        repeat (5) begin
            applyStimulus(1'b1, LW'(1'b0), 1'b0, 1'b0, 1'b0, acc);
            check("bp_no_accept", 32'(acc), 32'd0);
            check("bp_data", 32'(out_data), 32'hA5);
        end
        sendBits(8'h5A, 8, 1'b0, 1'b0, 0);
        checkOutput(8'h5A, 8, 1'b0);

        // Reset mid-word, then reset with a word held.
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
        sendBits(8'h0F, 4, 1'b0, 1'b1, 0);
        doReset();
        sendBits(8'h4D, 8, 1'b0, 1'b0, 0);
        checkOutput(8'h4D, 8, 1'b0);
        doReset();
        sendBits(8'h4D, 8, 1'b0, 1'b0, 0);
        checkOutput(8'h4D, 8, 1'b0);

        // Randomized traffic with gaps, flushes, order flips and backpressure.
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), LW'($urandom), 1'($urandom_range(0, 9) == 0),
                          1'($urandom), 1'($urandom_range(0, 9) < 7), acc);
        end
        tries = 0;
        while ((mdl_valid || beat_q.size() > 0) && tries < 40) begin
            if (beat_q.size() > 0)
                applyStimulus(1'b1, '0, 1'b1, 1'b0, 1'b1, acc);
            else
                applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
            tries++;
        end
        check("drain_done", 32'(mdl_valid), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_stream.md
Name: serial_to_parallel_stream

Overview:
- Generalised successor to the single-bit serial-to-parallel converter.
- Accepts lanes of `lane_width` bits per beat over a valid/ready handshake and assembles them into `width`-bit words.
- Lane order is selectable at run time (LSB-first or MSB-first). An `in_last` marker flushes a partial word early.
- Sits between a narrow serial front end (e.g. a deserialiser or UART-style bit source) and a word-wide stream consumer that may apply backpressure.

Parameters:
- `width`, default 8: output word width in bits. Must be a multiple of `lane_width`.
- `lane_width`, default 1: bits per input beat. Must be ≥ 1 and ≤ `width`.
- Derived `beats` = `width`/`lane_width`: number of lanes per full word.
- Derived `cnt_w` = $clog2(`beats`+1): width of `out_count`.

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `msb_first`  input  1  lane order for the next word: 0 = first beat in the low lane, 1 = first beat in the high lane.
- `in_valid`  input  1  input beat present.
- `in_ready`  output  1  block can accept a beat this cycle.
- `in_data`  input  `lane_width`  lane payload.
- `in_last`  input  1  this beat ends the current word (flush).
- `out_valid`  output  1  `out_data`, `out_count` and `out_last` are valid.
- `out_ready`  input  1  consumer accepts the word.
- `out_data`  output  `width`  assembled word.
- `out_count`  output  `cnt_w`  number of filled lanes in `out_data`, 1..`beats`.
- `out_last`  output  1  word was closed by `in_last`.

Behaviour:
- Reset: asynchronous on `rst_n` low, independent of `clk`. While `rst_n` is low and on release:
  - `out_valid`=0, `out_data`=0, `out_count`=0, `out_last`=0.
  - Lane counter=0, accumulator=0, latched order=0.
  - Reset mid-word discards partial data and any held output word.
- Handshakes:
  - A beat transfers when `in_valid` && `in_ready`.
  - A word transfers when `out_valid` && `out_ready`.
  - `in_ready` = !`out_valid` || `out_ready`. It is purely registered-state plus `out_ready`, and never depends on `in_valid`, `in_data` or `in_last`.
- States: ACCUM (lane counter `k` = 0..`beats`-1) and an output holding register (FULL/EMPTY by `out_valid`).
- Lane order:
  - `msb_first` is sampled on the accepted beat with `k`=0 and held for the whole word.
  - Changes to `msb_first` mid-word have no effect until the next word.
- Lane placement:
  - Accepted beat `k` writes `in_data` to lane index `k` (LSB-first) or `beats`-1-`k` (MSB-first).
  - Lane index `i` occupies bits [`i`*`lane_width` +: `lane_width`].
- Word completion: occurs on an accepted beat when `k` == `beats`-1 OR `in_last`=1. On the next edge:
  - `out_data` = accumulator including this beat; unfilled lanes are 0.
  - `out_count` = `k`+1.
  - `out_last` = `in_last`.
  - `out_valid` = 1.
  - Accumulator cleared to 0 and `k` = 0.
- `in_last` on the beat with `k` = `beats`-1: a full word with `out_count`=`beats` and `out_last`=1. No extra empty word is produced.
- Non-completing beat: `k` increments and the accumulator updates; outputs are untouched.
- Latency: `out_valid` rises 1 cycle after the completing beat is accepted.
- Throughput:
  - With `out_ready` held high, one beat per cycle sustained, and one full word every `beats` cycles.
  - A new completing beat may load the holding register in the same cycle the old word is consumed.
- Output drain: `out_valid` falls on the edge after `out_ready` is seen, unless a new word loads that same edge.
- Backpressure: while `out_valid`=1 and `out_ready`=0:
  - `in_ready`=0.
  - `out_data`, `out_count` and `out_last` are stable.
  - No beat is lost or duplicated.
- `in_valid`=0 cycles (gaps) freeze the accumulator and counter.
- Degenerate case `lane_width`=`width` (`beats`=1): every accepted beat completes a word with `out_count`=1.

Optional Feature:
- Macro: `SERIAL_TO_PARALLEL_PARITY_EN`.
- Defined:
  - Adds output port `out_parity` (1 bit) = XOR reduction of the word's `out_data`.
  - It is registered together with `out_data`, is 0 on reset, and holds under backpressure.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- `width`=8, `lane_width`=1, `msb_first`=0, bits 1,0,1,1,0,0,1,0 with no `in_last` -> one word `out_data`=8'h4D, `out_count`=8, `out_last`=0, 1 cycle after the 8th beat.
- Same bits with `msb_first`=1 -> `out_data`=8'hB2. Toggling `msb_first` after beat 3 does not change the result.
- `width`=8, `lane_width`=2, LSB-first lanes 2'b01, 2'b10, 2'b11, 2'b00 -> `out_data`=8'h39, `out_count`=4.
- Partial word, `lane_width`=1, bits 1,1,0 with `in_last` on the 3rd beat:
  - LSB-first -> `out_data`=8'h03, `out_count`=3, `out_last`=1.
  - MSB-first -> `out_data`=8'hC0.
  - The next word starts at lane 0.
- Backpressure: a word is pending and `out_ready`=0 for 5 cycles while `in_valid`=1 -> `in_ready`=0 and `out_data` stable throughout. Raising `out_ready` resumes with no lost beats. Back-to-back 8'hA5, 8'h5A are delivered in order.
- Reset: assert `rst_n`=0 asynchronously after 4 beats with a word held -> all outputs 0 immediately. After release, 8 fresh beats produce a correct full word (parity build: `out_parity` checked = ^`out_data`, e.g. 0 for 8'h4D).
